// File: rtl/ahb_to_ri5cy.sv
// AHB-Lite slave bridging single transfers onto a RI5CY req/gnt/rvalid port.
// One transfer in flight; illegal or timed-out transfers get a two-cycle ERROR.
module ahb_to_ri5cy #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hready_i,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
    output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
    output logic                      hreadyout_o,
    output logic                      hresp_o,
    output logic                      req_o,
    output logic                      we_o,
    output logic [3:0]                be_o,
    output logic [31:0]               addr_o,
    output logic [31:0]               wdata_o,
    input  logic                      gnt_i,
    input  logic                      rvalid_i,
    input  logic [31:0]               rdata_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RVAL = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_ERR1 = 3'd4;
    localparam logic [2:0] S_ERR2 = 3'd5;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]    r_state;
    logic [2:0]    w_nstate;
    logic          r_orphan;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic          r_write;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;

    logic [31:0]   w_haddr;
    logic          w_acc;
    logic          w_illegal;
    logic [3:0]    w_be;
    logic          w_busy;
    logic          w_to;
    logic          w_unused;

    generate
        if (AHB_ADDR_WIDTH >= 32) begin : g_addr_trunc
            assign w_haddr = haddr_i[31:0];
        end else begin : g_addr_ext
            assign w_haddr = {{(32-AHB_ADDR_WIDTH){1'b0}}, haddr_i};
        end
    endgenerate

    assign w_unused  = htrans_i[0];
    assign w_acc     = hsel_i & hready_i & htrans_i[1]
                     & ((r_state == S_IDLE) | (r_state == S_RESP));
    assign w_illegal = (hsize_i > 3'd2)
                     | ((hsize_i == 3'd1) & w_haddr[0])
                     | ((hsize_i == 3'd2) & (|w_haddr[1:0]));

    always_comb begin
        w_be = 4'b1111;
        case (hsize_i[1:0])
            2'd0:    w_be = 4'b0001 << w_haddr[1:0];
            2'd1:    w_be = w_haddr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // The request is withheld while a stale response is still owed to us.
    assign w_busy = (r_state == S_REQ) & ~r_orphan;
    assign w_to   = (TIMEOUT_CYCLES != 0) & (r_cnt == TO_LAST);

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_acc)
                    w_nstate = w_illegal ? S_ERR1 : S_REQ;
                else
                    w_nstate = S_IDLE;
            end
            S_REQ: begin
                if (!r_orphan) begin
                    if (gnt_i)
                        w_nstate = S_RVAL;
                    else if (w_to)
                        w_nstate = S_ERR1;
                end
            end
            S_RVAL: begin
                if (rvalid_i)
                    w_nstate = S_RESP;
                else if (w_to)
                    w_nstate = S_ERR1;
            end
            S_ERR1:  w_nstate = S_ERR2;
            S_ERR2:  w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_orphan <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_be     <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_acc) begin
                r_addr  <= {w_haddr[31:2], 2'b00};
                r_write <= hwrite_i;
                r_be    <= w_be;
            end
            if ((r_state == S_RVAL) && rvalid_i && !r_write)
                r_rdata <= rdata_i;
            if ((r_state == S_RVAL) && !rvalid_i && w_to)
                r_orphan <= 1'b1;
            else if (rvalid_i)
                r_orphan <= 1'b0;
            if ((w_nstate == S_REQ) && (r_state != S_REQ))
                r_cnt <= '0;
            else if (w_busy || (r_state == S_RVAL))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign hrdata_o    = r_rdata;
    assign hreadyout_o = (r_state == S_IDLE) | (r_state == S_RESP)
                       | (r_state == S_ERR2);
    assign hresp_o     = (r_state == S_ERR1) | (r_state == S_ERR2);
    assign req_o       = w_busy;
    assign we_o        = w_busy & r_write;
    assign be_o        = w_busy ? r_be : 4'b0000;
    assign addr_o      = r_addr;
    assign wdata_o     = hwdata_i;

endmodule

// File: tb/tb_ahb_to_ri5cy.sv
// Bench for ahb_to_ri5cy: AHB master driver, table-driven memory responder,
// and a queue-based scoreboard checking both sides of the bridge.
module tb_ahb_to_ri5cy;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [1:0]  htrans_i;
    logic        hready_i;
    logic [31:0] hwdata_i;
    logic [31:0] hrdata_o;
    logic        hreadyout_o;
    logic        hresp_o;
    logic        req_o;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;

    always #5 clk = ~clk;

    assign hready_i = hreadyout_o;

    ahb_to_ri5cy #(
        .AHB_ADDR_WIDTH(32),
        .AHB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .hsel_i(hsel_i), .haddr_i(haddr_i), .hwrite_i(hwrite_i),
        .hsize_i(hsize_i), .htrans_i(htrans_i), .hready_i(hready_i),
        .hwdata_i(hwdata_i), .hrdata_o(hrdata_o),
        .hreadyout_o(hreadyout_o), .hresp_o(hresp_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
        .rdata_i(rdata_i)
    );

    typedef struct {
        string       name;
        logic        err;
        logic        rd;
        logic [31:0] rdata;
        int          ncyc;
        logic        chk_next;
    } ahb_exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rvd;
    } mem_exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rv_t;

    ahb_exp_t ahb_q[$];
    mem_exp_t mem_q[$];
    rv_t      rv_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int gnt_delay = 0;
    int req_wait = 0;
    int req_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: grants after gnt_delay cycles, answers per table.
    always @(negedge clk) begin
        mem_exp_t m;
        rv_t      r;
        cyc++;
        gnt_i = 1'b0;
        rvalid_i = 1'b0;
        if (rv_q.size() > 0 && rv_q[0].due <= cyc) begin
            r = rv_q.pop_front();
            rvalid_i = 1'b1;
            rdata_i = r.data;
        end
        if (req_o) begin
            req_cnt++;
            if (req_wait >= gnt_delay) begin
                gnt_i = 1'b1;
                req_wait = 0;
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_unexpected: req at %h, none expected",
                             addr_o);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_we", {31'd0, we_o}, {31'd0, m.we});
                    check("mem_be", {28'd0, be_o}, {28'd0, m.be});
                    check("mem_addr", addr_o, m.addr);
                    if (m.we)
                        check("mem_wdata", wdata_o, m.wdata);
                    r.due = cyc + 1 + m.rvd;
                    r.data = m.rdata;
                    rv_q.push_back(r);
                end
            end else begin
                req_wait++;
            end
        end else begin
            req_wait = 0;
        end
    end

    logic dphase = 1'b0;
    int   dpcnt = 0;
    logic chk_req = 1'b0;

    // AHB monitor: pops one expectation per completed data phase.
    always @(negedge clk) begin
        ahb_exp_t e;
        if (chk_req) begin
            check("b2b_req_next", {31'd0, req_o}, 32'd1);
            chk_req = 1'b0;
        end
        if (dphase) begin
            dpcnt++;
            if (hreadyout_o) begin
                if (ahb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ahb_unexpected: completion, none expected");
                end else begin
                    e = ahb_q.pop_front();
                    check({e.name, "_hresp"}, {31'd0, hresp_o},
                          {31'd0, e.err});
                    if (e.rd && !e.err)
                        check({e.name, "_hrdata"}, hrdata_o, e.rdata);
                    if (e.ncyc > 0)
                        check({e.name, "_cycles"}, dpcnt, e.ncyc);
                    chk_req = e.chk_next;
                end
                dphase = 1'b0;
            end
        end
        if (hsel_i && htrans_i[1] && hreadyout_o) begin
            dphase = 1'b1;
            dpcnt = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!hreadyout_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!hreadyout_o) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: hreadyout %b required 1", hreadyout_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mem_exp(input logic w, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int rvd);
        mem_exp_t m;
        m.we = w; m.be = be; m.addr = a;
        m.wdata = wd; m.rdata = rd; m.rvd = rvd;
        mem_q.push_back(m);
    endtask

    task automatic addr_ph(input string nm, input logic [31:0] a,
                           input logic w, input logic [2:0] sz,
                           input logic [31:0] prev_wd, input logic err,
                           input logic [31:0] rd, input int ncyc,
                           input logic chk_next);
        ahb_exp_t e;
        e.name = nm; e.err = err; e.rd = !w; e.rdata = rd;
        e.ncyc = ncyc; e.chk_next = chk_next;
        ahb_q.push_back(e);
        hsel_i = 1'b1;
        htrans_i = 2'b10;
        haddr_i = a;
        hwrite_i = w;
        hsize_i = sz;
        hwdata_i = prev_wd;
        wait_ready();
    endtask

    task automatic idle_ph(input logic [31:0] wd);
        hsel_i = 1'b0;
        htrans_i = 2'b00;
        hwdata_i = wd;
        wait_ready();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        hsel_i = 1'b0; haddr_i = '0; hwrite_i = 1'b0; hsize_i = '0;
        htrans_i = '0; hwdata_i = '0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_hreadyout", {31'd0, hreadyout_o}, 32'd1);
        check("rst_hresp", {31'd0, hresp_o}, 32'd0);
        check("rst_hrdata", hrdata_o, 32'd0);
        check("rst_req", {31'd0, req_o}, 32'd0);
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_be", {28'd0, be_o}, 32'd0);
        @(posedge clk);
        #1;

        mem_exp(1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        addr_ph("rd_word", 32'h100, 1'b0, 3'd2, 32'h0, 1'b0,
                32'hDEADBEEF, 3, 1'b0);
        idle_ph(32'h0);

        mem_exp(1'b1, 4'h8, 32'h200, 32'hAB000000, 32'h0, 0);
        addr_ph("wr_byte", 32'h203, 1'b1, 3'd0, 32'h0, 1'b0, 32'h0, 3, 1'b0);
        idle_ph(32'hAB000000);

        mem_exp(1'b1, 4'hC, 32'h100, 32'h12340000, 32'h0, 0);
        addr_ph("wr_half", 32'h102, 1'b1, 3'd1, 32'h0, 1'b0, 32'h0, 3, 1'b0);
        idle_ph(32'h12340000);

        mem_exp(1'b0, 4'h2, 32'h100, 32'h0, 32'h0000CD00, 1);
        addr_ph("rd_byte", 32'h101, 1'b0, 3'd0, 32'h0, 1'b0,
                32'h0000CD00, 4, 1'b0);
        idle_ph(32'h0);

        addr_ph("half_misal", 32'h101, 1'b0, 3'd1, 32'h0, 1'b1, 32'h0, 2, 1'b0);
        idle_ph(32'h0);
        addr_ph("word_misal", 32'h102, 1'b1, 3'd2, 32'h0, 1'b1, 32'h0, 2, 1'b0);
        idle_ph(32'h0);
        addr_ph("size_dword", 32'h0, 1'b0, 3'd3, 32'h0, 1'b1, 32'h0, 2, 1'b0);
        idle_ph(32'h0);

        mem_exp(1'b0, 4'hF, 32'h104, 32'h0, 32'h11111111, 0);
        mem_exp(1'b0, 4'hF, 32'h108, 32'h0, 32'h22222222, 0);
        addr_ph("b2b_a", 32'h104, 1'b0, 3'd2, 32'h0, 1'b0,
                32'h11111111, 3, 1'b1);
        addr_ph("b2b_b", 32'h108, 1'b0, 3'd2, 32'h0, 1'b0,
                32'h22222222, 3, 1'b0);
        idle_ph(32'h0);

        gnt_delay = 100;
        req_cnt = 0;
        addr_ph("timeout_gnt", 32'h300, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0, 6, 1'b0);
        idle_ph(32'h0);
        check("timeout_req_cycles", req_cnt, 32'd4);
        check("timeout_req_low", {31'd0, req_o}, 32'd0);
        gnt_delay = 0;

        mem_exp(1'b0, 4'hF, 32'h400, 32'h0, 32'hBADBAD00, 8);
        addr_ph("timeout_rval", 32'h400, 1'b0, 3'd2, 32'h0, 1'b1,
                32'h0, 6, 1'b0);
        idle_ph(32'h0);
        req_cnt = 0;
        mem_exp(1'b0, 4'hF, 32'h404, 32'h0, 32'h12345678, 0);
        addr_ph("orphan_next", 32'h404, 1'b0, 3'd2, 32'h0, 1'b0,
                32'h12345678, 6, 1'b0);
        idle_ph(32'h0);
        check("orphan_req_cycles", req_cnt, 32'd1);

        mem_exp(1'b0, 4'h3, 32'h500, 32'h0, 32'h0000A5A5, 0);
        addr_ph("rd_half_lo", 32'h500, 1'b0, 3'd1, 32'h0, 1'b0,
                32'h0000A5A5, 3, 1'b0);
        idle_ph(32'h0);

        repeat (5) @(negedge clk);
        check("ahb_q_empty", ahb_q.size(), 32'd0);
        check("mem_q_empty", mem_q.size(), 32'd0);
        check("rv_q_empty", rv_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
